// File: rtl/debug_uart_pkg.sv
// Shared types and elaboration-time helpers for the buffered debug UART transmitter.
package debug_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int calc_clks_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Bit period must be a whole number of clocks (at least two); depth a power of two in 2..16.
    function automatic bit params_valid(input int clk_hz, input int bit_rate, input int depth);
        bit ok;
        ok = (bit_rate > 0) && ((clk_hz % bit_rate) == 0) && ((clk_hz / bit_rate) >= 2);
        ok = ok && (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
        return ok;
    endfunction

endpackage

// File: rtl/debug_uart_fifo.sv
// Single-clock byte FIFO; pointers carry one extra bit so full and empty are distinguishable.
module debug_uart_fifo
    import debug_uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DATA_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       wr_ptr_d;
    logic [AW:0]       rd_ptr_d;
    logic              push_ok;
    logic              pop_ok;

    // Full is judged on registered occupancy, so a write into a full FIFO is dropped
    // even when a pop happens on the same edge.
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign wr_ptr_d = wr_ptr + LW'(push_ok);
    assign rd_ptr_d = rd_ptr + LW'(pop_ok);
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            level  <= wr_ptr_d - rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/debug_uart_fifo_tx.sv
// Buffered 8N1 debug UART transmitter: byte FIFO feeding a START/DATA/STOP serialiser.
// Optional sticky overflow flag with clear input when DEBUG_UART_OVERFLOW_FLAG_EN is defined.
module debug_uart_fifo_tx
    import debug_uart_pkg::*;
#(
    parameter int CLK_HZ     = 64_000_000,
    parameter int BIT_RATE   = 4_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    output logic                         uart_txd,
    output logic                         busy,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  level
`ifdef DEBUG_UART_OVERFLOW_FLAG_EN
    ,
    output logic                         overflow,
    input  logic                         ovf_clear
`endif
);

    if (!params_valid(CLK_HZ, BIT_RATE, FIFO_DEPTH)) begin : g_param_check
        $error("debug_uart_fifo_tx: unsupported CLK_HZ/BIT_RATE/FIFO_DEPTH combination");
    end

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BIT_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t              state_q;
    tx_state_t              state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [2:0]             bit_idx_q;
    logic [2:0]             bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   fifo_rd_data;
    logic                   fifo_empty;
    logic                   pop;
    logic                   txd_d;

    debug_uart_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign busy = (level != '0) || (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    cnt_d   = CNT_MAX;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d   = DATA;
                    cnt_d     = CNT_MAX;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_MAX;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit so bursts have no idle gap.
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        state_d = START;
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        cnt_d   = CNT_MAX;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is registered, so it is derived from the state being entered.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            uart_txd  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            uart_txd  <= txd_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

`ifdef DEBUG_UART_OVERFLOW_FLAG_EN
    // A dropped write takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_debug_uart_fifo_tx.sv
// Directed scoreboard bench for debug_uart_fifo_tx: default instance plus a 2-clock-per-bit, depth-2 instance.
module tb_debug_uart_fifo_tx;

    localparam int CPB_A = 16;
    localparam int CPB_B = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en_a = 1'b0;
    logic       wr_en_b = 1'b0;
    logic [7:0] wr_data_a = 8'h00;
    logic [7:0] wr_data_b = 8'h00;
    logic       txd_a, busy_a, full_a;
    logic       txd_b, busy_b, full_b;
    logic [3:0] level_a;
    logic [1:0] level_b;
`ifdef DEBUG_UART_OVERFLOW_FLAG_EN
    logic       ovf_a, ovf_b;
    logic       ovf_clear_a = 1'b0;
    logic       ovf_clear_b = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    debug_uart_fifo_tx #(.CLK_HZ(64_000_000), .BIT_RATE(4_000_000), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .uart_txd(txd_a), .busy(busy_a), .full(full_a), .level(level_a)
`ifdef DEBUG_UART_OVERFLOW_FLAG_EN
        , .overflow(ovf_a), .ovf_clear(ovf_clear_a)
`endif
    );

    debug_uart_fifo_tx #(.CLK_HZ(64_000_000), .BIT_RATE(32_000_000), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .uart_txd(txd_b), .busy(busy_b), .full(full_b), .level(level_b)
`ifdef DEBUG_UART_OVERFLOW_FLAG_EN
        , .overflow(ovf_b), .ovf_clear(ovf_clear_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [7:0] d, input bit keep);
        wr_en_a   = 1'b1;
        wr_data_a = d;
        if (keep) q_a.push_back(d);
        @(negedge clk);
        wr_en_a = 1'b0;
    endtask

    task automatic wr_b(input logic [7:0] d, input bit keep);
        wr_en_b   = 1'b1;
        wr_data_b = d;
        if (keep) q_b.push_back(d);
        @(negedge clk);
        wr_en_b = 1'b0;
    endtask

    task automatic wait_idle_a(input int max_cyc, input string tag);
        int c = 0;
        while (busy_a !== 1'b0 && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        check(tag, busy_a, 1'b0);
    endtask

    task automatic wait_idle_b(input int max_cyc, input string tag);
        int c = 0;
        while (busy_b !== 1'b0 && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        check(tag, busy_b, 1'b0);
    endtask

    // Frame receivers: sample each bit mid-period, counted from the first low cycle.
    int         a_cnt = 0;
    bit         a_act = 1'b0;
    logic [7:0] a_sh  = 8'h00;
    logic [7:0] a_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_act = 1'b0;
        end else if (!a_act) begin
            if (txd_a === 1'b0) begin
                a_act = 1'b1;
                a_cnt = 0;
            end
        end else begin
            a_cnt++;
            if (a_cnt == CPB_A / 2) begin
                check("a_start_bit", txd_a, 1'b0);
            end else if ((a_cnt % CPB_A) == CPB_A / 2 && a_cnt < 9 * CPB_A) begin
                a_sh = {txd_a, a_sh[7:1]};
            end else if (a_cnt == 9 * CPB_A + CPB_A / 2) begin
                check("a_stop_bit", txd_a, 1'b1);
                check("a_frame_expected", 32'(q_a.size() != 0), 1);
                if (q_a.size() != 0) begin
                    a_exp = q_a.pop_front();
                    check("a_frame_data", a_sh, a_exp);
                end
            end
            if (a_cnt == 10 * CPB_A - 1) a_act = 1'b0;
        end
    end

    int         b_cnt = 0;
    bit         b_act = 1'b0;
    logic [7:0] b_sh  = 8'h00;
    logic [7:0] b_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            b_act = 1'b0;
        end else if (!b_act) begin
            if (txd_b === 1'b0) begin
                b_act = 1'b1;
                b_cnt = 0;
            end
        end else begin
            b_cnt++;
            if (b_cnt == CPB_B / 2) begin
                check("b_start_bit", txd_b, 1'b0);
            end else if ((b_cnt % CPB_B) == CPB_B / 2 && b_cnt < 9 * CPB_B) begin
                b_sh = {txd_b, b_sh[7:1]};
            end else if (b_cnt == 9 * CPB_B + CPB_B / 2) begin
                check("b_stop_bit", txd_b, 1'b1);
                check("b_frame_expected", 32'(q_b.size() != 0), 1);
                if (q_b.size() != 0) begin
                    b_exp = q_b.pop_front();
                    check("b_frame_data", b_sh, b_exp);
                end
            end
            if (b_cnt == 10 * CPB_B - 1) b_act = 1'b0;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_txd", txd_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_full", full_a, 1'b0);
        check("rst_level", level_a, 4'd0);
        check("rst_txd_b", txd_b, 1'b1);
`ifdef DEBUG_UART_OVERFLOW_FLAG_EN
        check("rst_overflow", ovf_a, 1'b0);
        check("rst_overflow_b", ovf_b, 1'b0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x55; after wr_a we sample in cycle N+1
        wr_a(8'h55, 1'b1);
        check("single_busy_n1", busy_a, 1'b1);
        check("single_level_n1", level_a, 4'd1);
        check("single_txd_n1", txd_a, 1'b1);
        @(negedge clk);
        check("single_txd_start_n2", txd_a, 1'b0);
        check("single_level_n2", level_a, 4'd0);
        repeat (159) @(negedge clk);
        check("single_busy_n161", busy_a, 1'b1);
        check("single_txd_stop_n161", txd_a, 1'b1);
        @(negedge clk);
        check("single_busy_n162", busy_a, 1'b0);
        check("single_sb_drained", q_a.size(), 0);

        // Burst of three bytes, no idle gap
        repeat (5) @(negedge clk);
        wr_a(8'h01, 1'b1);
        wr_a(8'h80, 1'b1);
        wr_a(8'hFF, 1'b1);
        check("burst_level_n3", level_a, 4'd2);
        repeat (478) @(negedge clk);
        check("burst_busy_n481", busy_a, 1'b1);
        @(negedge clk);
        check("burst_busy_n482", busy_a, 1'b0);
        check("burst_sb_drained", q_a.size(), 0);

        // Overflow: nine accepted, tenth dropped
        repeat (5) @(negedge clk);
        for (int i = 0; i < 9; i++) wr_a(8'(8'hA0 + i), 1'b1);
        check("ovf_level_n9", level_a, 4'd8);
        check("ovf_full_n9", full_a, 1'b1);
        wr_a(8'hEE, 1'b0);
        check("ovf_level_after_drop", level_a, 4'd8);
`ifdef DEBUG_UART_OVERFLOW_FLAG_EN
        check("ovf_flag_set", ovf_a, 1'b1);
`endif
        wait_idle_a(9 * 160 + 50, "ovf_drain_idle");
        check("ovf_sb_drained", q_a.size(), 0);

`ifdef DEBUG_UART_OVERFLOW_FLAG_EN
        // Clear, then clear coincident with a dropped write
        check("ovf_flag_held", ovf_a, 1'b1);
        ovf_clear_a = 1'b1;
        @(negedge clk);
        ovf_clear_a = 1'b0;
        check("ovf_flag_cleared", ovf_a, 1'b0);
        for (int i = 0; i < 9; i++) wr_a(8'(8'hC0 + i), 1'b1);
        ovf_clear_a = 1'b1;
        wr_a(8'h99, 1'b0);
        ovf_clear_a = 1'b0;
        check("ovf_set_beats_clear", ovf_a, 1'b1);
        wait_idle_a(9 * 160 + 50, "ovf2_drain_idle");
        check("ovf2_sb_drained", q_a.size(), 0);
        ovf_clear_a = 1'b1;
        @(negedge clk);
        ovf_clear_a = 1'b0;
        check("ovf_flag_cleared2", ovf_a, 1'b0);
`endif

        // Reset during data bit 3 of 0xF0 (bit 3 is 0)
        repeat (5) @(negedge clk);
        wr_a(8'hF0, 1'b0);
        wr_a(8'h5A, 1'b0);
        repeat (68) @(negedge clk);
        check("midrst_txd_bit3", txd_a, 1'b0);
        check("midrst_busy_before", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_txd_async", txd_a, 1'b1);
        check("midrst_busy_async", busy_a, 1'b0);
        check("midrst_level_async", level_a, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("midrst_level_after", level_a, 4'd0);
        check("midrst_busy_after", busy_a, 1'b0);
        check("midrst_txd_after", txd_a, 1'b1);

        // Two clocks per bit, depth 2: fill, then wrap the pointers
        wr_b(8'h11, 1'b1);
        wr_b(8'h22, 1'b1);
        wr_b(8'h33, 1'b1);
        check("sweep_level_n3", level_b, 2'd2);
        check("sweep_full_n3", full_b, 1'b1);
        repeat (30) @(negedge clk);
        wr_b(8'hC4, 1'b1);
        repeat (12) @(negedge clk);
        wr_b(8'h3B, 1'b1);
        wait_idle_b(200, "sweep_idle");
        check("sweep_sb_drained", q_b.size(), 0);
        check("sweep_level_end", level_b, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
